// File: rtl/shift_pkg.sv
// Shared widths and FSM state encoding for the two-requester shift arbiter.
package shift_pkg;
  localparam int DATA_W = 8;
  localparam int AMT_W  = 3;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;
endpackage

// File: rtl/barrel_shift.sv
// Combinational logical left shift; zeros fill from the bottom, overflow bits are dropped.
module barrel_shift
  import shift_pkg::*;
(
  input  logic [DATA_W-1:0] i_data,
  input  logic [AMT_W-1:0]  i_amt,
  output logic [DATA_W-1:0] o_data
);

  assign o_data = i_data << i_amt;

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter between two shift requesters feeding a single
// one-deep result register with valid/ready backpressure.
module shift_arbiter
  import shift_pkg::*;
#(
  parameter logic RR_INIT = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_data,
  input  logic [AMT_W-1:0]  req0_amt,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_data,
  input  logic [AMT_W-1:0]  req1_amt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_src
);

  state_t              r_state;
  state_t              w_nextState;
  logic                r_prio;
  logic [DATA_W-1:0]   r_data;
  logic                r_src;

  logic                w_free;
  logic                w_grant;
  logic                w_sel;
  logic [DATA_W-1:0]   w_opData;
  logic [AMT_W-1:0]    w_opAmt;
  logic [DATA_W-1:0]   w_shifted;

  assign out_valid = (r_state == FULL);
  assign out_data  = r_data;
  assign out_src   = r_src;

  // rst_n gates the grant so no ready can leak out while reset is held.
  assign w_free  = !out_valid || out_ready;
  assign w_grant = rst_n && w_free && (req0_valid || req1_valid);
  assign w_sel   = (req0_valid && req1_valid) ? r_prio : req1_valid;

  assign req0_ready = w_grant && !w_sel;
  assign req1_ready = w_grant && w_sel;

  assign w_opData = w_sel ? req1_data : req0_data;
  assign w_opAmt  = w_sel ? req1_amt  : req0_amt;

  barrel_shift u_shift (
    .i_data (w_opData),
    .i_amt  (w_opAmt),
    .o_data (w_shifted)
  );

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      EMPTY: if (w_grant) w_nextState = FULL;
      FULL:  if (out_ready && !w_grant) w_nextState = EMPTY;
      default: w_nextState = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_prio  <= RR_INIT;
      r_data  <= '0;
      r_src   <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if (w_grant) begin
        r_prio <= !w_sel;
        r_data <= w_shifted;
        r_src  <= w_sel;
      end
    end
  end

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: directed vector table, reset corners and a random run.
module tb_shift_arbiter;

  typedef struct {
    logic       v0;
    logic [7:0] d0;
    logic [2:0] a0;
    logic       v1;
    logic [7:0] d1;
    logic [2:0] a1;
    logic       ordy;
    logic [1:0] expRdy;
    logic       chkOut;
    logic [7:0] expOut;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       src;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [7:0] req0_data, req1_data;
  logic [2:0] req0_amt, req1_amt;
  logic       out_valid, out_ready, out_src;
  logic [7:0] out_data;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  logic mFull;
  logic mPrio;
  vec_t tbl[16];

  shift_arbiter #(.RR_INIT(1'b0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_data  (req0_data),
    .req0_amt   (req0_amt),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_data  (req1_data),
    .req1_amt   (req1_amt),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_src    (out_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] modelShift(input logic [7:0] d, input logic [2:0] a);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++)
      if (i >= int'(a)) r[i] = d[i - int'(a)];
    return r;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    req0_valid = v.v0;
    req0_data  = v.d0;
    req0_amt   = v.a0;
    req1_valid = v.v1;
    req1_data  = v.d1;
    req1_amt   = v.a1;
    out_ready  = v.ordy;
  endtask

  // Compares readies and the held result against the scoreboard, then advances the model.
  task automatic checkOutput(input logic useExp, input logic [1:0] expRdy);
    logic mFree, mGrant, mSel;
    logic [1:0] rdy;
    exp_t e;
    #1;
    mFree  = !mFull || out_ready;
    mGrant = mFree && (req0_valid || req1_valid);
    mSel   = (req0_valid && req1_valid) ? mPrio : req1_valid;
    rdy    = useExp ? expRdy : {mGrant && mSel, mGrant && !mSel};
    check("req0_ready", {7'b0, req0_ready}, {7'b0, rdy[0]});
    check("req1_ready", {7'b0, req1_ready}, {7'b0, rdy[1]});
    check("out_valid", {7'b0, out_valid}, {7'b0, mFull});
    if (mFull) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL scoreboard: got empty queue, expected a result at %0t", $time);
      end else begin
        check("out_data", out_data, q[0].data);
        check("out_src", {7'b0, out_src}, {7'b0, q[0].src});
      end
    end
    if (mFull && out_ready && q.size() > 0) void'(q.pop_front());
    if (mGrant) begin
      e.data = mSel ? modelShift(req1_data, req1_amt) : modelShift(req0_data, req0_amt);
      e.src  = mSel;
      q.push_back(e);
      mFull = 1'b1;
      mPrio = !mSel;
    end else if (mFull && out_ready) begin
      mFull = 1'b0;
    end
  endtask

  task automatic resetModel();
    q.delete();
    mFull = 1'b0;
    mPrio = 1'b0;
  endtask

  initial begin
    vec_t v;
    tbl[0]  = '{1'b1, 8'h81, 3'd0, 1'b1, 8'h81, 3'd7, 1'b1, 2'b01, 1'b0, 8'h00};
    tbl[1]  = '{1'b1, 8'hFE, 3'd7, 1'b1, 8'h81, 3'd7, 1'b1, 2'b10, 1'b1, 8'h81};
    tbl[2]  = '{1'b1, 8'h3C, 3'd1, 1'b1, 8'h0F, 3'd4, 1'b1, 2'b01, 1'b1, 8'h80};
    tbl[3]  = '{1'b1, 8'h3C, 3'd1, 1'b1, 8'h0F, 3'd4, 1'b1, 2'b10, 1'b1, 8'h78};
    tbl[4]  = '{1'b1, 8'hB5, 3'd3, 1'b0, 8'h00, 3'd0, 1'b1, 2'b01, 1'b1, 8'hF0};
    tbl[5]  = '{1'b0, 8'h00, 3'd0, 1'b1, 8'hFE, 3'd7, 1'b0, 2'b00, 1'b1, 8'hA8};
    tbl[6]  = '{1'b0, 8'h00, 3'd0, 1'b1, 8'hFE, 3'd7, 1'b0, 2'b00, 1'b1, 8'hA8};
    tbl[7]  = '{1'b1, 8'h11, 3'd2, 1'b1, 8'hFE, 3'd7, 1'b0, 2'b00, 1'b1, 8'hA8};
    tbl[8]  = '{1'b0, 8'h00, 3'd0, 1'b1, 8'hFE, 3'd7, 1'b0, 2'b00, 1'b1, 8'hA8};
    tbl[9]  = '{1'b0, 8'h00, 3'd0, 1'b1, 8'hFE, 3'd7, 1'b1, 2'b10, 1'b1, 8'hA8};
    tbl[10] = '{1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 3'd0, 1'b1, 2'b00, 1'b1, 8'h00};
    tbl[11] = '{1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 3'd0, 1'b1, 2'b00, 1'b0, 8'h00};
    tbl[12] = '{1'b1, 8'h81, 3'd7, 1'b1, 8'h55, 3'd2, 1'b0, 2'b01, 1'b0, 8'h00};
    tbl[13] = '{1'b1, 8'h81, 3'd7, 1'b1, 8'h55, 3'd2, 1'b0, 2'b00, 1'b1, 8'h80};
    tbl[14] = '{1'b1, 8'h81, 3'd0, 1'b1, 8'h55, 3'd2, 1'b1, 2'b01, 1'b0, 8'h00};
    tbl[15] = '{1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 3'd0, 1'b1, 2'b00, 1'b1, 8'h81};

    resetModel();
    rst_n = 1'b0;
    applyStimulus(tbl[0]);
    #3;
    check("rst req0_ready", {7'b0, req0_ready}, 8'h00);
    check("rst req1_ready", {7'b0, req1_ready}, 8'h00);
    check("rst out_valid", {7'b0, out_valid}, 8'h00);
    check("rst out_data", out_data, 8'h00);
    check("rst out_src", {7'b0, out_src}, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      if (i > 0) @(negedge clk);
      applyStimulus(tbl[i]);
      if (tbl[i].chkOut) check($sformatf("vec%0d out_data", i), out_data, tbl[i].expOut);
      checkOutput(1'b1, tbl[i].expRdy);
    end

    $display("[TB] asserting reset while result register is full");
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst out_valid", {7'b0, out_valid}, 8'h00);
    check("midrst out_data", out_data, 8'h00);
    resetModel();
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(tbl[14]);
    checkOutput(1'b1, tbl[14].expRdy);
    @(negedge clk);
    applyStimulus(tbl[15]);
    check("post-rst out_data", out_data, tbl[15].expOut);
    checkOutput(1'b1, tbl[15].expRdy);

    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      v.v0   = 1'($urandom_range(0, 1));
      v.d0   = 8'($urandom);
      v.a0   = 3'($urandom);
      v.v1   = 1'($urandom_range(0, 1));
      v.d1   = 8'($urandom);
      v.a1   = 3'($urandom);
      v.ordy = ($urandom_range(0, 3) != 0);
      v.expRdy = 2'b00;
      v.chkOut = 1'b0;
      v.expOut = 8'h00;
      applyStimulus(v);
      checkOutput(1'b0, 2'b00);
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_arbiter.md
SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 The module SHALL have one parameter: RR_INIT, default 1'b0, the requester that holds round-robin priority after reset.
REQ-002 The module SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1, the reset; it is asynchronous and active-low.
REQ-004 The module SHALL have port req0_valid, input, 1, requester 0 has a shift request pending.
REQ-005 The module SHALL have port req0_ready, output, 1, requester 0 request accepted this cycle.
REQ-006 The module SHALL have port req0_data, input, 8, requester 0 operand.
REQ-007 The module SHALL have port req0_amt, input, 3, requester 0 left-shift amount.
REQ-008 The module SHALL have ports req1_valid, req1_ready, req1_data and req1_amt, with the same directions, widths and meanings for requester 1.
REQ-009 The module SHALL have port out_valid, output, 1, the result register holds a result.
REQ-010 The module SHALL have port out_ready, input, 1, the consumer accepts the result this cycle.
REQ-011 The module SHALL have port out_data, output, 8, the shifted result.
REQ-012 The module SHALL have port out_src, output, 1, the index of the requester that produced out_data.

Function
REQ-013 The result register is free when out_valid is 0, or when out_valid and out_ready are both 1 in the same cycle.
REQ-014 A grant SHALL occur only in a cycle where the result register is free and at least one reqN_valid is 1.
- Only one requester valid: that requester is granted.
- Both valid: the requester holding priority is granted.
REQ-015 reqN_ready SHALL be combinational and equal to 1 only for the granted requester; at most one ready is high per cycle.
REQ-016 On a grant, the priority pointer SHALL move to the non-granted requester on the next edge; without a grant, the pointer is held.
REQ-017 On a grant, the next edge SHALL load the following:
- out_data: operand shifted left logically by amt, zero-filled, bits shifted past bit 7 discarded.
- out_src: the granted index.
- out_valid: 1.
REQ-018 Latency SHALL be one cycle from grant to out_valid=1; sustained throughput is one result per cycle while out_ready=1.
REQ-019 The FSM SHALL have two states:
- EMPTY (out_valid=0): a grant moves it to FULL.
- FULL (out_valid=1): out_ready=1 with no grant moves it to EMPTY; out_ready=1 with a grant stays FULL with the new result; out_ready=0 stays FULL.
REQ-020 While FULL and out_ready=0, out_data and out_src SHALL hold stable and both reqN_ready outputs SHALL be 0 (backpressure).
REQ-021 amt=0 SHALL pass the operand through unchanged; amt=7 SHALL yield {operand[0], 7'b0}.
REQ-022 Requesters may change data, amt or valid while not granted; only values sampled in the grant cycle SHALL be used.

Reset
REQ-023 While rst_n=0, the outputs and state SHALL be:
- out_valid=0, out_data=8'h00, out_src=0.
- Priority pointer=RR_INIT.
- req0_ready=0, req1_ready=0.
REQ-024 Reset asserted mid-operation SHALL discard any held result immediately; no result is presented after release until a new grant.

Structure
REQ-025 The FSM state enum (EMPTY, FULL) and the width constants (DATA_W=8, AMT_W=3) SHALL reside in the shared package shift_pkg.
REQ-026 The shift SHALL be performed by one instance of the existing combinational barrel_shift sub-module, fed by a 2:1 grant multiplexer; no other sub-modules.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- Reset: hold rst_n=0 with both valid -> both ready=0, out_valid=0, out_data=8'h00; release -> first grant goes to requester RR_INIT.
- Single request: req0 data=8'hB5, amt=3, out_ready=1 -> req0_ready=1 for one cycle; next cycle out_valid=1, out_data=8'hA8, out_src=0.
- Contention: both valid continuously, out_ready=1, RR_INIT=0 -> grants alternate 0,1,0,1 and out_src alternates likewise, one result per cycle.
- Backpressure: FULL with out_ready=0 for 4 cycles -> out_data held stable, both ready=0; then out_ready=1 with req1 valid -> same-cycle grant, new result next cycle.
- Boundaries: amt=0 with data=8'h81 -> 8'h81; amt=7 with data=8'h81 -> 8'h80; amt=7 with data=8'hFE -> 8'h00.
- Reset mid-operation: assert rst_n=0 while FULL -> out_valid falls without waiting for a clock edge; pointer returns to RR_INIT.
